mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller between the CPU core and the byte-wide unified RAM/IO port.
- Acts as the responder to the instruction cache's miss requests: takes a 32-bit fetch address, performs four byte reads, and returns the assembled little-endian word with a one-cycle valid pulse.
- Also serves the load/store buffer, for byte, half and word reads/writes.
- Arbitrates between the two channels, honours rdy, rollback and the IO-buffer-full backpressure.

Parameters:
- IO_BASE, 32'h0003_0000, lowest address of the memory-mapped IO region (addr[17:16]==2'b11).
- RAM_LAT, 1, cycles between presenting mem_a and mem_din being valid; fixed at 1, kept for documentation.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset. Asserted (0) clears state immediately, independent of clk.
- rdy  in  1  global ready. When 0, state, counters and outputs hold. mem_wr is forced 0.
- rollback  in  1  pipeline flush; aborts in-flight fetch and load.
- io_buffer_full  in  1  IO write buffer full; blocks IO-region writes.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- IC_addr  in  32  fetch address from icache.
- IC_addr_sgn  in  1  level request from icache; held until served.
- IC_val  out  32  fetched instruction word.
- IC_val_sgn  out  1  one-cycle pulse: IC_val valid.
- LS_addr  in  32  data address.
- LS_sgn  in  1  level request from load/store buffer.
- LS_wr  in  1  1 = store, 0 = load.
- LS_len  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- LS_wdata  in  32  store data; the low bytes are used.
- LS_rdata  out  32  load data, zero-extended. Sign extension is done by the consumer.
- LS_done  out  1  one-cycle pulse: access complete.

Behaviour:
- Reset values: state IDLE, byte counter 0, mem_a=0, mem_wr=0, mem_dout=0, IC_val=0, IC_val_sgn=0, LS_rdata=0, LS_done=0.
- States: IDLE, IREAD, DREAD, DWRITE.
- IDLE, rdy=1, rollback=0:
  - LS_sgn wins over IC_addr_sgn.
  - If neither is pending, stay in IDLE.
  - On grant: latch the address, length and wdata; go to IREAD, DREAD or DWRITE; counter = 0.
  - No new grant in the cycle a done or val pulse is high. The requester deasserts on that pulse, which prevents a re-grant of a stale request.
- Pulses: IC_val_sgn and LS_done are high for exactly one cycle, then return to 0. They never assert together.
- Read sequence (IREAD, DREAD), n = 4 for IREAD, else 1, 2 or 4 from LS_len:
  - Present mem_a = base + k on successive cycles, k = 0..n-1, with mem_wr=0.
  - Byte k is sampled from mem_din one cycle after its address and placed at data[8k+7:8k].
  - On the cycle after byte n-1 is sampled: pulse IC_val_sgn or LS_done, drive the data, return to IDLE.
  - Fetch latency: grant edge T → IC_val_sgn high in the cycle after edge T+5.
- DWRITE:
  - Drive mem_a = base + k, mem_dout = wdata[8k+7:8k], mem_wr=1 for k = 0..n-1, one byte per cycle.
  - LS_done pulses the cycle after the last byte; mem_wr returns to 0.
  - If the address is in the IO region and io_buffer_full=1: hold with mem_wr=0 and the counter frozen until it clears.
- Address arithmetic: base + k is modulo 2^32; wrap from 32'hFFFF_FFFF to 0 is legal.
- rollback=1:
  - In IREAD or DREAD: abort to IDLE next cycle with no pulse; clear IC_val_sgn.
  - In DWRITE: the store is committed and always finishes.
  - In IDLE: no grant that cycle.
- rdy=0: freeze everything; resume exactly where frozen.
- Reset mid-access: return to IDLE immediately, no pulse, no further writes.
- mem_a outside active states is 0; mem_wr is 0 outside DWRITE.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00, IC_addr=0x100 held → one IC_val_sgn pulse, IC_val=32'h0010_0513, at grant+5 cycles; no LS_done.
- Arbitration: LS load byte @0x200 (RAM=0xF0) and fetch @0x0 requested together → LS_done first with LS_rdata=32'h0000_00F0, then the fetch completes.
- Store half: LS_wr=1, len=1, addr=0x404, wdata=0xABCD → mem writes CD@0x404 then AB@0x405, one LS_done; readback word = 0x0000ABCD (upper bytes preset 0).
- IO stall: store byte to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 for those cycles, then a single write; LS_done 1 cycle later.
- Rollback mid-fetch at grant+2 → no IC_val_sgn, IDLE next cycle; a rollback during DWRITE still completes all bytes.
- Async reset (rst=0) mid-DREAD between edges → outputs zero immediately; after release, a new fetch is served normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller: serves icache fetches and load/store accesses
// over a byte-wide RAM/IO port with arbitration and backpressure.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic [31:0] IC_addr,
  input  logic        IC_addr_sgn,
  output logic [31:0] IC_val,
  output logic        IC_val_sgn,
  input  logic [31:0] LS_addr,
  input  logic        LS_sgn,
  input  logic        LS_wr,
  input  logic [1:0]  LS_len,
  input  logic [31:0] LS_wdata,
  output logic [31:0] LS_rdata,
  output logic        LS_done
);

  typedef enum logic [1:0] {
    IDLE,
    IREAD,
    DREAD,
    DWRITE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] data;
  logic [31:0] merged;
  logic [31:0] cur_a;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [2:0]  len_n;
  logic [7:0]  hold;
  logic [7:0]  din_eff;
  logic [7:0]  wbyte;
  logic [1:0]  idx;
  logic        held;
  logic        rd_st;
  logic        stall;
  logic        lat_ok;
  logic        gnt_ls;
  logic        gnt_ic;
  logic        fin;
  logic        step;
  logic        smp;

  assign cur_a  = base + {29'd0, cnt};
  assign rd_st  = (state == IREAD) || (state == DREAD);
  assign lat_ok = cnt >= RAM_LAT[2:0];
  assign idx    = cnt[1:0] - 2'd1;
  assign wbyte  = wdata[{cnt[1:0], 3'b000} +: 8];

  // A byte that arrived while frozen is parked so resume sees it
  assign din_eff = held ? hold : mem_din;

  assign stall = (state == DWRITE) && io_buffer_full &&
                 (cur_a[17:16] == IO_BASE[17:16]);

  assign mem_a    = (state == IDLE) ? 32'd0 : cur_a;
  assign mem_wr   = (state == DWRITE) && rdy && !stall;
  assign mem_dout = (state == DWRITE) ? wbyte : 8'd0;

  always_comb begin
    merged = data;
    merged[{idx, 3'b000} +: 8] = din_eff;
  end

  always_comb begin
    len_n = 3'd4;
    unique case (1'b1)
      LS_len == 2'd0: len_n = 3'd1;
      LS_len == 2'd1: len_n = 3'd2;
      default:        len_n = 3'd4;
    endcase
  end

  always_comb begin
    state_nx = state;
    gnt_ls   = 1'b0;
    gnt_ic   = 1'b0;
    fin      = 1'b0;
    step     = 1'b0;
    smp      = 1'b0;
    if (rdy) begin
      unique case (state)
        IDLE: begin
          if (!rollback && !IC_val_sgn && !LS_done) begin
            if (LS_sgn) begin
              gnt_ls   = 1'b1;
              state_nx = LS_wr ? DWRITE : DREAD;
            end else if (IC_addr_sgn) begin
              gnt_ic   = 1'b1;
              state_nx = IREAD;
            end
          end
        end
        IREAD, DREAD: begin
          if (rollback) begin
            state_nx = IDLE;
          end else begin
            smp = lat_ok;
            if (cnt == nbytes) begin
              fin      = 1'b1;
              state_nx = IDLE;
            end else begin
              step = 1'b1;
            end
          end
        end
        DWRITE: begin
          if (!stall) begin
            if (cnt == nbytes - 3'd1) begin
              fin      = 1'b1;
              state_nx = IDLE;
            end else begin
              step = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base       <= 32'd0;
      wdata      <= 32'd0;
      data       <= 32'd0;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      hold       <= 8'd0;
      held       <= 1'b0;
      IC_val     <= 32'd0;
      IC_val_sgn <= 1'b0;
      LS_rdata   <= 32'd0;
      LS_done    <= 1'b0;
    end else begin
      IC_val_sgn <= 1'b0;
      LS_done    <= 1'b0;
      if (!rdy) begin
        if (rd_st && lat_ok && !held) begin
          hold <= mem_din;
          held <= 1'b1;
        end
      end else begin
        held <= 1'b0;
      end
      if (gnt_ls || gnt_ic) begin
        base   <= gnt_ls ? LS_addr : IC_addr;
        nbytes <= gnt_ls ? len_n : 3'd4;
        wdata  <= LS_wdata;
        cnt    <= 3'd0;
        data   <= 32'd0;
      end
      if (step) begin
        cnt <= cnt + 3'd1;
      end
      if (smp) begin
        data <= merged;
      end
      if (fin) begin
        unique case (state)
          IREAD: begin
            IC_val     <= merged;
            IC_val_sgn <= 1'b1;
          end
          DREAD: begin
            LS_rdata <= merged;
            LS_done  <= 1'b1;
          end
          default: LS_done <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array model of memory.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [31:0] IC_addr;
  logic        IC_addr_sgn;
  logic [31:0] IC_val;
  logic        IC_val_sgn;
  logic [31:0] LS_addr;
  logic        LS_sgn;
  logic        LS_wr;
  logic [1:0]  LS_len;
  logic [31:0] LS_wdata;
  logic [31:0] LS_rdata;
  logic        LS_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn),
    .IC_val(IC_val), .IC_val_sgn(IC_val_sgn),
    .LS_addr(LS_addr), .LS_sgn(LS_sgn), .LS_wr(LS_wr),
    .LS_len(LS_len), .LS_wdata(LS_wdata),
    .LS_rdata(LS_rdata), .LS_done(LS_done)
  );

  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];

  function automatic logic [7:0] rram(logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] mrd(logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  function automatic int nb(logic [1:0] l);
    return (l == 2'd0) ? 1 : ((l == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] mread(logic [31:0] a, int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = mrd(a + 32'(i));
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pre(logic [31:0] a, logic [7:0] b);
    ram[a] = b;
    mdl[a] = b;
  endtask

  // Synchronous RAM: one cycle from address to data
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= rram(mem_a);
  end

  logic [31:0] ic_cap, ls_a_cap, ls_d_cap;
  logic [1:0]  ls_l_cap;
  logic        ls_w_cap;
  int          wk = 0;
  logic        prev_ic = 0, prev_ls = 0, prev_p = 0;

  always @(negedge clk) begin
    if (!rst) begin
      wk = 0;
      prev_ic = 0;
      prev_ls = 0;
      prev_p = 0;
    end else begin
      if (IC_addr_sgn) ic_cap = IC_addr;
      if (LS_sgn) begin
        ls_a_cap = LS_addr;
        ls_d_cap = LS_wdata;
        ls_l_cap = LS_len;
        ls_w_cap = LS_wr;
      end
      if (mem_wr) begin
        check("wr_is_store", {31'd0, prev_ls && ls_w_cap}, 32'd1);
        check("wr_rdy", {31'd0, rdy}, 32'd1);
        check("wr_io_block",
              {31'd0, io_buffer_full && mem_a[17:16] == 2'b11}, 32'd0);
        check("wr_addr", mem_a, ls_a_cap + 32'(wk));
        check("wr_data", {24'd0, mem_dout},
              {24'd0, ls_d_cap[8*(wk%4) +: 8]});
        wk++;
      end
      if (IC_val_sgn || LS_done)
        check("pulse_width", {31'd0, prev_p}, 32'd0);
      if (IC_val_sgn) begin
        check("ic_requested", {31'd0, prev_ic}, 32'd1);
        check("no_both", {31'd0, LS_done}, 32'd0);
        check("ic_val", IC_val, mread(ic_cap, 4));
      end
      if (LS_done) begin
        check("ls_requested", {31'd0, prev_ls}, 32'd1);
        if (ls_w_cap) begin
          check("st_bytes", wk, nb(ls_l_cap));
          for (int i = 0; i < nb(ls_l_cap); i++)
            mdl[ls_a_cap + 32'(i)] = ls_d_cap[8*i +: 8];
          wk = 0;
        end else begin
          check("ld_data", LS_rdata, mread(ls_a_cap, nb(ls_l_cap)));
        end
      end
      prev_ic = IC_addr_sgn;
      prev_ls = LS_sgn;
      prev_p = IC_val_sgn || LS_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_p(input bit ic, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(ic ? IC_val_sgn : LS_done) && lat < 200);
    if (lat >= 200) begin
      total++;
      bad++;
      $display("FAIL pulse_timeout: got none expected pulse");
    end
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFE + 32'($urandom_range(0, 1));
      1: return 32'h0003_0000 + 32'($urandom_range(0, 7));
      default: return 32'h0000_1000 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  int lat, wcnt, lw, iw, seen;
  bit drain;

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    IC_addr = 0; IC_addr_sgn = 0; LS_addr = 0; LS_sgn = 0;
    LS_wr = 0; LS_len = 0; LS_wdata = 0;
    pre(32'h100, 8'h13); pre(32'h101, 8'h05);
    pre(32'h102, 8'h10); pre(32'h103, 8'h00);
    pre(32'h200, 8'hF0);
    pre(32'h0, 8'h11); pre(32'h1, 8'h22);
    pre(32'h2, 8'h33); pre(32'h3, 8'h44);
    for (int i = 0; i < 40; i++) pre(32'h1000 + 32'(i), 8'($urandom));
    pre(32'hFFFF_FFFE, 8'h5C); pre(32'hFFFF_FFFF, 8'hA7);
    tick(); tick();
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_dout", {24'd0, mem_dout}, 0);
    check("rst_ic", IC_val, 0);
    check("rst_ls", LS_rdata, 0);
    check("rst_pulses", {30'd0, IC_val_sgn, LS_done}, 0);
    rst = 1'b1;
    tick();

    IC_addr = 32'h100; IC_addr_sgn = 1;
    wait_p(1, lat);
    IC_addr_sgn = 0;
    check("fetch_lat", lat, 6);
    check("fetch_val", IC_val, 32'h0010_0513);
    check("fetch_no_ls", {31'd0, LS_done}, 0);
    tick();

    LS_addr = 32'h200; LS_len = 0; LS_wr = 0; LS_sgn = 1;
    IC_addr = 32'h0; IC_addr_sgn = 1;
    lat = 0;
    do begin tick(); lat++; end while (!IC_val_sgn && !LS_done && lat < 200);
    check("arb_ls_first", {30'd0, LS_done, IC_val_sgn}, 32'd2);
    check("arb_ls_data", LS_rdata, 32'h0000_00F0);
    LS_sgn = 0;
    wait_p(1, lat);
    IC_addr_sgn = 0;
    check("arb_ic_val", IC_val, 32'h4433_2211);
    tick();

    LS_addr = 32'h404; LS_len = 1; LS_wr = 1; LS_wdata = 32'hABCD; LS_sgn = 1;
    wait_p(0, lat);
    LS_sgn = 0;
    check("sth_ram", {rram(32'h407), rram(32'h406), rram(32'h405),
                      rram(32'h404)}, 32'h0000_ABCD);
    tick();
    LS_len = 2; LS_wr = 0; LS_sgn = 1;
    wait_p(0, lat);
    LS_sgn = 0;
    check("sth_readback", LS_rdata, 32'h0000_ABCD);
    tick();

    io_buffer_full = 1;
    LS_addr = 32'h0003_0000; LS_len = 0; LS_wr = 1; LS_wdata = 32'h5A;
    LS_sgn = 1;
    tick();
    wcnt = 0;
    repeat (3) begin
      if (mem_wr) wcnt++;
      tick();
    end
    check("io_stall_nowr", wcnt, 0);
    check("io_stall_nodone", {31'd0, LS_done}, 0);
    io_buffer_full = 0;
    #1;
    check("io_wr_go", {31'd0, mem_wr}, 1);
    tick();
    check("io_done", {31'd0, LS_done}, 1);
    LS_sgn = 0;
    check("io_ram", {24'd0, rram(32'h0003_0000)}, 32'h5A);
    tick();

    IC_addr = 32'h100; IC_addr_sgn = 1;
    tick(); tick();
    rollback = 1; IC_addr_sgn = 0;
    tick();
    rollback = 0;
    check("rb_idle", mem_a, 0);
    seen = 0;
    repeat (8) begin
      if (IC_val_sgn) seen++;
      tick();
    end
    check("rb_no_pulse", seen, 0);

    LS_addr = 32'h500; LS_len = 2; LS_wr = 1; LS_wdata = 32'h1122_3344;
    LS_sgn = 1;
    tick(); tick();
    rollback = 1;
    tick(); tick();
    rollback = 0;
    wait_p(0, lat);
    LS_sgn = 0;
    check("rb_store", {rram(32'h503), rram(32'h502), rram(32'h501),
                       rram(32'h500)}, 32'h1122_3344);
    tick();

    LS_addr = 32'h404; LS_len = 2; LS_wr = 0; LS_sgn = 1;
    tick(); tick();
    #1 rst = 0;
    #1;
    check("arst_mem_a", mem_a, 0);
    check("arst_ls", LS_rdata, 0);
    check("arst_done", {30'd0, LS_done, mem_wr}, 0);
    LS_sgn = 0;
    tick();
    rst = 1;
    tick();
    IC_addr = 32'h100; IC_addr_sgn = 1;
    wait_p(1, lat);
    IC_addr_sgn = 0;
    check("arst_fetch_lat", lat, 6);
    check("arst_fetch_val", IC_val, 32'h0010_0513);
    tick();

    lw = 0; iw = 0; drain = 0;
    for (int c = 0; c < 4500; c++) begin
      tick();
      if (c >= 4000) drain = 1;
      rdy = drain ? 1'b1 : ($urandom_range(0, 7) != 0);
      io_buffer_full = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
      if (LS_sgn) begin
        lw++;
        if (LS_done) begin
          LS_sgn = 0; lw = 0;
        end else if (lw > 400) begin
          check("ls_timeout", lw, 0);
          LS_sgn = 0; lw = 0;
        end
      end else if (!drain && $urandom_range(0, 3) == 0) begin
        LS_addr = pick(); LS_len = 2'($urandom_range(0, 3));
        LS_wr = 1'($urandom_range(0, 1)); LS_wdata = $urandom;
        LS_sgn = 1;
      end
      if (IC_addr_sgn) begin
        iw++;
        if (IC_val_sgn) begin
          IC_addr_sgn = 0; iw = 0;
        end else if (iw > 400) begin
          check("ic_timeout", iw, 0);
          IC_addr_sgn = 0; iw = 0;
        end
      end else if (!drain && $urandom_range(0, 3) == 0) begin
        IC_addr = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFE
                : 32'h1000 + 32'($urandom_range(0, 31));
        IC_addr_sgn = 1;
      end
    end
    check("drained", {30'd0, LS_sgn, IC_addr_sgn}, 0);
    foreach (mdl[k]) check("ram_final", {24'd0, rram(k)}, {24'd0, mdl[k]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
